// File: rtl/controller_pkg.sv
// Shared constants for the controller front end.
//   - button bit positions in the 8-bit controller word
//   - default timing parameters (100 MHz clock)
//   - repeat FSM state encodings
//   - counter width helper
package controller_pkg;

  localparam int NUM_BTNS = 8;

  // Bit map of the controller word
  localparam int BTN_START = 7;
  localparam int BTN_A     = 6;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 4;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  // 5 ms debounce, 400 ms to first repeat, 150 ms between repeats
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 40000000;
  localparam int unsigned DEF_REPEAT_RATE     = 15000000;
  // d-pad only
  localparam logic [NUM_BTNS-1:0] DEF_REPEAT_MASK = 8'h0F;

  // Repeat FSM encodings
  localparam logic [1:0] RPT_IDLE  = 2'd0;
  localparam logic [1:0] RPT_DELAY = 2'd1;
  localparam logic [1:0] RPT_RATE  = 2'd2;

  // One spare bit above what the largest count needs, so saturation
  // headroom never collides with the terminal value.
  function automatic int cnt_width(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/button_event_gen_channel.sv
// button_channel: one controller button.
//   Synchronises the raw level, debounces it, and turns debounced edges
//   into one-cycle press / release pulses, with optional auto-repeat of
//   press while the button stays held.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   raw             - asynchronous button level, 1 = pressed
//   repeat_en       - global auto-repeat enable
//   held            - debounced level
//   press           - pulse on accepted press and on each auto-repeat
//   release_pulse   - pulse on accepted release
module button_channel
  import controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter bit          REPEAT_ALLOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic repeat_en,
  output logic held,
  output logic press,
  output logic release_pulse
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int RPT_W = cnt_width(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]       rpt_state_q, rpt_state_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

  logic disagree, accept, rise, fall, rpt_ok, rpt_fire;

  // Synchroniser and debounce
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    held_d   = held_q;
    db_cnt_d = '0;
    disagree = (s2_q != held_q);
    accept   = 1'b0;
    if (disagree) begin
      // The edge that sees the counter at its last value is the
      // DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
      if (db_cnt_q >= DB_LAST) begin
        accept = 1'b1;
        held_d = ~held_q;
      end else if (db_cnt_q != '1) begin
        db_cnt_d = db_cnt_q + 1'b1;
      end else begin
        db_cnt_d = db_cnt_q;
      end
    end
    rise = accept & ~held_q;
    fall = accept &  held_q;
  end

  // Auto-repeat. Dropping the enable (or the button) parks the FSM in
  // IDLE; only a fresh debounced rise can leave IDLE, so re-enabling
  // mid-hold does not resume repeating.
  always_comb begin
    rpt_ok      = REPEAT_ALLOW && repeat_en;
    rpt_state_d = rpt_state_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_fire    = 1'b0;
    if (!rpt_ok || fall) begin
      rpt_state_d = RPT_IDLE;
      rpt_cnt_d   = '0;
    end else begin
      case (rpt_state_q)
        RPT_IDLE: begin
          rpt_cnt_d = '0;
          if (rise) rpt_state_d = RPT_DELAY;
        end
        RPT_DELAY: begin
          if (rpt_cnt_q >= DELAY_LAST) begin
            rpt_fire    = 1'b1;
            rpt_state_d = RPT_RATE;
            rpt_cnt_d   = '0;
          end else if (rpt_cnt_q != '1) begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        RPT_RATE: begin
          if (rpt_cnt_q >= RATE_LAST) begin
            rpt_fire  = 1'b1;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q != '1) begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        default: begin
          rpt_state_d = RPT_IDLE;
          rpt_cnt_d   = '0;
        end
      endcase
    end
    // Pulses are registered alongside held, so they line up with the
    // first cycle held shows the new level. A fall always wins over a
    // repeat landing on the same edge (the FSM is forced idle above).
    press_d   = rise | rpt_fire;
    release_d = fall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      held_q      <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      db_cnt_q    <= '0;
      rpt_state_q <= RPT_IDLE;
      rpt_cnt_q   <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      held_q      <= held_d;
      press_q     <= press_d;
      release_q   <= release_d;
      db_cnt_q    <= db_cnt_d;
      rpt_state_q <= rpt_state_d;
      rpt_cnt_q   <= rpt_cnt_d;
    end
  end

  assign held          = held_q;
  assign press         = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/button_event_gen.sv
// button_event_gen: debounced button levels and press/release events for
// an 8-button controller, with per-button auto-repeat on press.
// Ports:
//   clk            - 100 MHz system clock
//   reset          - synchronous, active-high
//   buttons_raw    - raw levels, 1 = pressed (bit map in controller_pkg)
//   repeat_en      - global auto-repeat enable
//   held           - debounced level per button
//   press          - one-cycle pulse per accepted press or auto-repeat
//   release_pulse  - one-cycle pulse per accepted release
module button_event_gen
  import controller_pkg::*;
#(
  parameter int unsigned          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned          REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned          REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter logic [NUM_BTNS-1:0]  REPEAT_MASK     = DEF_REPEAT_MASK
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] buttons_raw,
  input  logic                repeat_en,
  output logic [NUM_BTNS-1:0] held,
  output logic [NUM_BTNS-1:0] press,
  output logic [NUM_BTNS-1:0] release_pulse
);

  // Channels share nothing but clock, reset and the global enable.
  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_ALLOW    (REPEAT_MASK[g])
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .raw           (buttons_raw[g]),
      .repeat_en     (repeat_en),
      .held          (held[g]),
      .press         (press[g]),
      .release_pulse (release_pulse[g])
    );
  end

endmodule
